mcu_bus_ctrl: RTL and testbench

- Microcontroller bus slave and configuration controller for the TH99CHLS top.
- Decodes the multiplexed address/data bus transaction (CSbar, ALE, Rbar, Wbar) and maintains the configuration register file: coefficients B0..B6, operand, hour, minute.
- Drives the configuration to the filter/clock datapath, and issues a time-load pulse when hour or minute is written.
- Returns register contents on DBUS during read cycles.

---
 rtl/mcu_bus_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mcu_bus_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_ctrl.sv
// Microcontroller bus slave for the TH99CHLS top: decodes the multiplexed
// address/data bus and holds the filter coefficients, operand and time registers.
module mcu_bus_ctrl #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W+7:0] BASE_ADDR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            ABUS,
    inout  wire  [DATA_W-1:0]     DBUS,
    input  logic                  CSbar,
    input  logic                  ALE,
    input  logic                  Rbar,
    input  logic                  Wbar,
    output logic [7*DATA_W-1:0]   coef,
    output logic [DATA_W-1:0]     operand,
    output logic [DATA_W-1:0]     time_hour,
    output logic [DATA_W-1:0]     time_minute,
    output logic                  time_load,
    output logic                  busy
);

    localparam int AW = DATA_W + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ARMED,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                prev_ale, prev_rbar, prev_wbar;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       off;
    logic [DATA_W-1:0]   bank_q [8];
    logic [DATA_W-1:0]   hour_q, minute_q;
    logic                status_q;
    logic                time_load_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                dbus_oe_q;
    logic                addr_ld, wr_commit, rd_start, rd_end;
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_val;
    logic                ale_fall, rbar_fall, wbar_fall;

    assign ale_fall  = prev_ale && !ALE;
    assign rbar_fall = prev_rbar && !Rbar;
    assign wbar_fall = prev_wbar && !Wbar;

    // Offset wraps modulo 2^AW, so addresses below the window land far above it.
    assign off = addr_q - BASE_ADDR;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: CSbar low frames a transaction; ALE high carries {ABUS,DBUS};
    // the first falling Wbar (or Rbar) afterwards performs the single access.
    // CSbar high aborts from any state, dropping anything not yet committed.
    always_comb begin
        state_d   = state_q;
        addr_ld   = 1'b0;
        wr_commit = 1'b0;
        rd_start  = 1'b0;
        rd_end    = 1'b0;
        if (CSbar) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ALE) begin
                        state_d = S_ADDR;
                        addr_ld = 1'b1;
                    end
                end
                S_ADDR: begin
                    if (ALE) begin
                        addr_ld = 1'b1;
                    end else if (ale_fall) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (wbar_fall) begin
                        state_d   = S_WRITE;
                        wr_commit = 1'b1;
                    end else if (rbar_fall) begin
                        state_d  = S_READ;
                        rd_start = 1'b1;
                    end
                end
                S_WRITE: state_d = S_DONE;
                S_READ: begin
                    if (Rbar) begin
                        state_d = S_DONE;
                        rd_end  = 1'b1;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ok = 1'b0;
        if (off < AW'(8)) begin
            wr_ok = 1'b1;
        end else if (off == AW'(8)) begin
            wr_ok = (DBUS <= DATA_W'(23));
        end else if (off == AW'(9)) begin
            wr_ok = (DBUS <= DATA_W'(59));
        end
    end

    always_comb begin
        rd_val = '0;
        if (off < AW'(8)) begin
            rd_val = bank_q[off[2:0]];
        end else if (off == AW'(8)) begin
            rd_val = hour_q;
        end else if (off == AW'(9)) begin
            rd_val = minute_q;
        end else if (off == AW'(10)) begin
            rd_val = {{(DATA_W-1){1'b0}}, status_q};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_ale  <= 1'b0;
            prev_rbar <= 1'b1;
            prev_wbar <= 1'b1;
            addr_q    <= '0;
        end else begin
            prev_ale  <= ALE;
            prev_rbar <= Rbar;
            prev_wbar <= Wbar;
            if (addr_ld) begin
                addr_q <= {ABUS, DBUS};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
            hour_q      <= '0;
            minute_q    <= '0;
            status_q    <= 1'b0;
            time_load_q <= 1'b0;
            rdata_q     <= '0;
            dbus_oe_q   <= 1'b0;
        end else begin
            time_load_q <= 1'b0;
            if (wr_commit) begin
                if (wr_ok) begin
                    status_q <= 1'b0;
                    if (off < AW'(8)) begin
                        bank_q[off[2:0]] <= DBUS;
                    end else if (off == AW'(8)) begin
                        hour_q      <= DBUS;
                        time_load_q <= 1'b1;
                    end else begin
                        minute_q    <= DBUS;
                        time_load_q <= 1'b1;
                    end
                end else begin
                    status_q <= 1'b1;
                end
            end
            if (rd_start) begin
                rdata_q <= rd_val;
            end
            if (CSbar || rd_end) begin
                dbus_oe_q <= 1'b0;
            end else if (rd_start) begin
                dbus_oe_q <= 1'b1;
            end
        end
    end

    // CSbar gating releases the bus in the very cycle the chip is deselected.
    assign DBUS = (dbus_oe_q && !CSbar) ? rdata_q : {DATA_W{1'bz}};

    for (genvar i = 0; i < 7; i++) begin : g_coef
        assign coef[i*DATA_W +: DATA_W] = bank_q[i];
    end

    assign operand     = bank_q[7];
    assign time_hour   = hour_q;
    assign time_minute = minute_q;
    assign time_load   = time_load_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Directed bench for mcu_bus_ctrl: table of bus writes/reads with hand-computed
// results, then hand-written abort, strobe-collision and reset-mid-read sequences.
module tb_mcu_bus_ctrl;

    logic        clock;
    logic        reset;
    logic [7:0]  abus;
    wire  [7:0]  dbus;
    logic        csbar, ale, rbar, wbar;
    logic [55:0] coef;
    logic [7:0]  operand, time_hour, time_minute;
    logic        time_load, busy;

    logic [7:0]  tb_dbus;
    logic        tb_drv;

    int n_checks = 0;
    int n_errors = 0;
    int tl_cycles = 0;

    // A released bus reads as all ones.
    localparam logic [7:0] FLOAT = 8'hFF;

    assign dbus = tb_drv ? tb_dbus : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (dbus[i]);
    end

    mcu_bus_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .ABUS        (abus),
        .DBUS        (dbus),
        .CSbar       (csbar),
        .ALE         (ale),
        .Rbar        (rbar),
        .Wbar        (wbar),
        .coef        (coef),
        .operand     (operand),
        .time_hour   (time_hour),
        .time_minute (time_minute),
        .time_load   (time_load),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (time_load === 1'b1) tl_cycles++;
    end

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic        exp_tl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic [15:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rd, input logic exp_tl);
        vec_t v;
        v.rd = rd; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_tl = exp_tl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addr_phase(input logic [15:0] addr);
        @(negedge clock);
        csbar = 1'b0; ale = 1'b1; abus = addr[15:8]; tb_dbus = addr[7:0]; tb_drv = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             output logic tl1, output logic tl2);
        addr_phase(addr);
        @(negedge clock); ale = 1'b0; tb_dbus = data;
        @(negedge clock); wbar = 1'b0;
        @(negedge clock); tl1 = time_load; wbar = 1'b1;
        @(negedge clock); tl2 = time_load; csbar = 1'b1; tb_drv = 1'b0;
        @(negedge clock);
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] z0,
                            output logic [7:0] d1, output logic [7:0] d2, output logic [7:0] z1);
        addr_phase(addr);
        @(negedge clock); ale = 1'b0; tb_drv = 1'b0;
        @(negedge clock); z0 = dbus; rbar = 1'b0;
        @(negedge clock); d1 = dbus;
        @(negedge clock); d2 = dbus; rbar = 1'b1;
        @(negedge clock); z1 = dbus; csbar = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic       tl1, tl2;
        logic [7:0] z0, d1, d2, z1;
        string      nm;

        reset = 1'b1; csbar = 1'b1; ale = 1'b0; rbar = 1'b1; wbar = 1'b1;
        abus = '0; tb_dbus = '0; tb_drv = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_coef", coef, 56'h0);
        check("reset_busy", busy, 0);
        check("reset_dbus", dbus, FLOAT);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", {operand, time_hour, time_minute, 7'b0, time_load}, 32'h0);

        for (int i = 0; i < 7; i++) add(1'b0, 16'(i), 8'd10, 8'h00, 1'b0);
        add(1'b0, 16'd7,   8'hFF,  8'h00, 1'b0);
        add(1'b0, 16'd8,   8'd23,  8'h00, 1'b1);
        add(1'b0, 16'd9,   8'd33,  8'h00, 1'b1);
        add(1'b1, 16'd10,  8'h00,  8'h00, 1'b0);
        add(1'b1, 16'd8,   8'h00,  8'd23, 1'b0);
        add(1'b1, 16'd9,   8'h00,  8'd33, 1'b0);
        add(1'b0, 16'd8,   8'd24,  8'h00, 1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h01, 1'b0);
        add(1'b1, 16'd8,   8'h00,  8'd23, 1'b0);
        add(1'b0, 16'd9,   8'd0,   8'h00, 1'b1);
        add(1'b1, 16'd10,  8'h00,  8'h00, 1'b0);
        add(1'b1, 16'd5,   8'h00,  8'd10, 1'b0);
        add(1'b1, 16'd200, 8'h00,  8'h00, 1'b0);
        add(1'b0, 16'd10,  8'd55,  8'h00, 1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h01, 1'b0);
        add(1'b0, 16'd0,   8'h5A,  8'h00, 1'b0);
        add(1'b1, 16'd0,   8'h00,  8'h5A, 1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h00, 1'b0);
        add(1'b0, 16'h0100, 8'd7,  8'h00, 1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h01, 1'b0);
        add(1'b1, 16'h0100, 8'h00, 8'h00, 1'b0);
        add(1'b1, 16'd7,   8'h00,  8'hFF, 1'b0);
        add(1'b0, 16'd9,   8'd60,  8'h00, 1'b0);
        add(1'b1, 16'd9,   8'h00,  8'd0,  1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h01, 1'b0);
        add(1'b0, 16'd9,   8'd59,  8'h00, 1'b1);
        add(1'b1, 16'd9,   8'h00,  8'd59, 1'b0);
        add(1'b1, 16'd10,  8'h00,  8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rd) begin
                bus_read(vecs[i].addr, z0, d1, d2, z1);
                nm = $sformatf("v%0d_rd_%0d", i, vecs[i].addr);
                check({nm, "_pre"},  z0, FLOAT);
                check({nm, "_d1"},   d1, vecs[i].exp_rd);
                check({nm, "_d2"},   d2, vecs[i].exp_rd);
                check({nm, "_post"}, z1, FLOAT);
            end else begin
                bus_write(vecs[i].addr, vecs[i].wdata, tl1, tl2);
                nm = $sformatf("v%0d_wr_%0d", i, vecs[i].addr);
                check({nm, "_tl"},   tl1, vecs[i].exp_tl);
                check({nm, "_tl_w"}, tl2, 0);
            end
            if (i == 6) check("coef_all_10", coef, {7{8'd10}});
            if (i == 9) check("hour_min_23_33", {time_hour, time_minute}, {8'd23, 8'd33});
        end
        check("final_coef", coef, 56'h0A0A0A0A0A0A5A);
        check("final_operand", operand, 8'hFF);
        check("final_time", {time_hour, time_minute}, {8'd23, 8'd59});
        check("tl_pulse_count", tl_cycles, 4);

        // Deselect in ARMED together with a falling Wbar: nothing may commit.
        addr_phase(16'd8);
        @(negedge clock); ale = 1'b0; tb_dbus = 8'd5;
        @(negedge clock); check("abort_busy_armed", busy, 1); csbar = 1'b1; wbar = 1'b0;
        @(negedge clock); check("abort_busy_idle", busy, 0); wbar = 1'b1; tb_drv = 1'b0;
        @(negedge clock);
        check("abort_hour", time_hour, 8'd23);
        check("abort_tl_count", tl_cycles, 4);

        // Both strobes fall together: the write wins and the bus stays released.
        addr_phase(16'd7);
        @(negedge clock); ale = 1'b0; tb_dbus = 8'h3C;
        @(negedge clock); wbar = 1'b0; rbar = 1'b0;
        @(negedge clock); tb_drv = 1'b0; #1 check("both_dbus_1", dbus, FLOAT);
        @(negedge clock); check("both_dbus_2", dbus, FLOAT); wbar = 1'b1; rbar = 1'b1; csbar = 1'b1;
        @(negedge clock);
        check("both_operand", operand, 8'h3C);
        bus_read(16'd10, z0, d1, d2, z1);
        check("both_status", d1, 8'h00);

        // Reset in the middle of a read.
        addr_phase(16'd5);
        @(negedge clock); ale = 1'b0; tb_drv = 1'b0;
        @(negedge clock); rbar = 1'b0;
        @(negedge clock); check("rst_read_data", dbus, 8'd10);
        reset = 1'b1;
        #1;
        check("rst_dbus", dbus, FLOAT);
        check("rst_busy", busy, 0);
        check("rst_regs", {coef, operand, time_hour, time_minute}, 80'h0);
        check("rst_tl", time_load, 0);
        @(negedge clock); reset = 1'b0; rbar = 1'b1; csbar = 1'b1;
        @(negedge clock); check("rst_idle", busy, 0);
        bus_read(16'd5, z0, d1, d2, z1);
        check("rst_readback", d1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
